// File: rtl/mem_addr_unit.sv
// -----------------------------------------------------------------------------
// mem_addr_unit
//
// Registered memory-address selector for the multicycle datapath. One of NSRC
// address sources is latched on a request and presented to memory until memory
// answers with mem_ready or a wait-cycle watchdog gives up on the access.
//
// Optional feature macro: MEM_ADDR_ALIGN_CHECK_EN
//   defined   : misaligned half/word requests are redirected to EXC_VECTOR
//               through the FAULT state with misalign raised.
//   undefined : every request issues its selected address, misalign is 0
//               and size is unused.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   sel        in   source index (0 PC, 1 exception, 2 ALU, 3 result);
//                   out-of-range values select slot 0
//   src_flat   in   concatenated sources, slot i at [i*WIDTH +: WIDTH]
//   size       in   00 byte, 01 half, 1x word
//   req        in   access request, only sampled while idle
//   mem_ready  in   memory accepted the presented address
//   addr_out   out  registered address, held after the access ends
//   addr_valid out  addr_out is being presented to memory
//   misalign   out  current access is an alignment-fault redirect
//   timeout    out  one-cycle pulse when the watchdog aborts an access
//   busy       out  an access is in progress
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_addr_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NSRC       = 4,
  parameter int unsigned SELW       = $clog2(NSRC),
  parameter logic [31:0] EXC_VECTOR = 32'h000000FD,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SELW-1:0]       sel,
  input  logic [NSRC*WIDTH-1:0] src_flat,
  input  logic [1:0]            size,
  input  logic                  req,
  input  logic                  mem_ready,
  output logic [WIDTH-1:0]      addr_out,
  output logic                  addr_valid,
  output logic                  misalign,
  output logic                  timeout,
  output logic                  busy
);

  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

`ifdef MEM_ADDR_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] ExcAddr = WIDTH'(EXC_VECTOR);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StFault
  } state_e;
`else
  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } state_e;
`endif

  state_e           r_state_q, w_state_d;
  logic [WIDTH-1:0] r_addr_q, w_addr_d;
  logic             r_valid_q, w_valid_d;
  logic             r_mis_q, w_mis_d;
  logic             r_timeout_q, w_timeout_d;
  logic [CntW-1:0]  r_wait_q, w_wait_d;
  logic [CntW-1:0]  w_wait_inc;
  logic [WIDTH-1:0] w_src;

  // Source mux; any index without a matching slot falls back to slot 0 (PC).
  always_comb begin
    w_src = src_flat[WIDTH-1:0];
    for (int i = 1; i < int'(NSRC); i++) begin
      if (sel == SELW'(i)) begin
        w_src = src_flat[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MEM_ADDR_ALIGN_CHECK_EN
  logic w_fault;

  always_comb begin
    w_fault = 1'b0;
    unique case (size)
      2'b01:        w_fault = w_src[0];
      2'b10, 2'b11: w_fault = |w_src[1:0];
      default:      w_fault = 1'b0;
    endcase
  end
`else
  logic w_unused_size;
  assign w_unused_size = ^size;
`endif

  // Saturating so the counter can never wrap back into a live range.
  assign w_wait_inc = (r_wait_q == CntMax) ? r_wait_q : r_wait_q + 1'b1;

  always_comb begin
    w_state_d   = r_state_q;
    w_addr_d    = r_addr_q;
    w_valid_d   = r_valid_q;
    w_mis_d     = r_mis_q;
    w_timeout_d = 1'b0;
    w_wait_d    = r_wait_q;

    unique case (r_state_q)
      StIdle: begin
        w_valid_d = 1'b0;
        w_mis_d   = 1'b0;
        w_wait_d  = '0;
        if (req) begin
          w_valid_d = 1'b1;
`ifdef MEM_ADDR_ALIGN_CHECK_EN
          if (w_fault) begin
            w_state_d = StFault;
            w_addr_d  = ExcAddr;
            w_mis_d   = 1'b1;
          end else begin
            w_state_d = StIssue;
            w_addr_d  = w_src;
          end
`else
          w_state_d = StIssue;
          w_addr_d  = w_src;
`endif
        end
      end

      // ISSUE and FAULT share the handshake and watchdog behaviour.
      default: begin
        if (mem_ready) begin
          // mem_ready takes priority over a watchdog expiry in the same cycle.
          w_state_d = StIdle;
          w_valid_d = 1'b0;
          w_mis_d   = 1'b0;
          w_wait_d  = '0;
        end else if (w_wait_inc == CntMax) begin
          w_state_d   = StIdle;
          w_valid_d   = 1'b0;
          w_mis_d     = 1'b0;
          w_timeout_d = 1'b1;
          w_wait_d    = '0;
        end else begin
          w_wait_d = w_wait_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q   <= StIdle;
      r_addr_q    <= '0;
      r_valid_q   <= 1'b0;
      r_mis_q     <= 1'b0;
      r_timeout_q <= 1'b0;
      r_wait_q    <= '0;
    end else begin
      r_state_q   <= w_state_d;
      r_addr_q    <= w_addr_d;
      r_valid_q   <= w_valid_d;
      r_mis_q     <= w_mis_d;
      r_timeout_q <= w_timeout_d;
      r_wait_q    <= w_wait_d;
    end
  end

  assign addr_out   = r_addr_q;
  assign addr_valid = r_valid_q;
  assign misalign   = r_mis_q;
  assign timeout    = r_timeout_q;
  assign busy       = (r_state_q != StIdle);

endmodule

// File: tb/tb_mem_addr_unit.sv
`timescale 1ns/1ps

module tb_mem_addr_unit;

`ifdef MEM_ADDR_ALIGN_CHECK_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  localparam logic [31:0] ExcVec = 32'h000000FD;

  typedef struct {
    logic [31:0] addr;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        reset_n;

  // Main instance: 4 sources, short watchdog.
  logic [1:0]   sel;
  logic [31:0]  src [4];
  logic [127:0] src_flat;
  logic [1:0]   size;
  logic         req;
  logic         mem_ready;
  logic [31:0]  addr_out;
  logic         addr_valid;
  logic         misalign;
  logic         timeout;
  logic         busy;

  // Second instance: 3 sources, for out-of-range select.
  logic [1:0]  sel3;
  logic [31:0] src3 [3];
  logic [95:0] src_flat3;
  logic        req3;
  logic        mem_ready3;
  logic [31:0] addr_out3;
  logic        addr_valid3;
  logic        misalign3;
  logic        timeout3;
  logic        busy3;

  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  logic prev_valid;

  assign src_flat  = {src[3], src[2], src[1], src[0]};
  assign src_flat3 = {src3[2], src3[1], src3[0]};

  mem_addr_unit #(
    .WIDTH     (32),
    .NSRC      (4),
    .EXC_VECTOR(ExcVec),
    .TIMEOUT   (4)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sel       (sel),
    .src_flat  (src_flat),
    .size      (size),
    .req       (req),
    .mem_ready (mem_ready),
    .addr_out  (addr_out),
    .addr_valid(addr_valid),
    .misalign  (misalign),
    .timeout   (timeout),
    .busy      (busy)
  );

  mem_addr_unit #(
    .WIDTH     (32),
    .NSRC      (3),
    .EXC_VECTOR(ExcVec),
    .TIMEOUT   (255)
  ) u_dut3 (
    .clk       (clk),
    .reset_n   (reset_n),
    .sel       (sel3),
    .src_flat  (src_flat3),
    .size      (2'b10),
    .req       (req3),
    .mem_ready (mem_ready3),
    .addr_out  (addr_out3),
    .addr_valid(addr_valid3),
    .misalign  (misalign3),
    .timeout   (timeout3),
    .busy      (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [1:0] sz);
    exp_t e;
    logic f;
    f = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    e.addr = (AlignEn && f) ? ExcVec : a;
    e.mis  = AlignEn && f;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on the main instance and record what it must present.
  task automatic start(input int s, input logic [31:0] a, input logic [1:0] sz);
    src[s] = a;
    sel    = 2'(s);
    size   = sz;
    req    = 1'b1;
    sb_q.push_back(model(a, sz));
    tick();
    req = 1'b0;
  endtask

  task automatic finish_access();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  // Scoreboard: every new presentation of an address must match the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && addr_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_access", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_addr", addr_out, e.addr);
        check("sb_misalign", {31'd0, misalign}, {31'd0, e.mis});
      end
    end
    prev_valid <= addr_valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] tbl_addr [5];
    logic [1:0]  tbl_size [5];
    int          tbl_sel  [5];

    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    sel        = '0;
    size       = '0;
    req        = 1'b0;
    mem_ready  = 1'b0;
    sel3       = '0;
    req3       = 1'b0;
    mem_ready3 = 1'b0;
    for (int i = 0; i < 4; i++) src[i] = '0;
    for (int i = 0; i < 3; i++) src3[i] = '0;

    tick();
    tick();
    check("rst_addr", addr_out, 32'd0);
    check("rst_valid", {31'd0, addr_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Normal word access, memory answers after three cycles.
    start(2, 32'h0000_0100, 2'b10);
    check("word_addr", addr_out, 32'h100);
    check("word_valid", {31'd0, addr_valid}, 32'd1);
    check("word_busy", {31'd0, busy}, 32'd1);
    tick();
    tick();
    check("word_wait_valid", {31'd0, addr_valid}, 32'd1);
    finish_access();
    check("word_done_valid", {31'd0, addr_valid}, 32'd0);
    check("word_done_busy", {31'd0, busy}, 32'd0);
    check("word_hold_addr", addr_out, 32'h100);
    check("word_no_timeout", {31'd0, timeout}, 32'd0);

    // Misaligned word from the result slot.
    start(3, 32'h0000_0102, 2'b10);
    check("misw_addr", addr_out, AlignEn ? ExcVec : 32'h102);
    check("misw_flag", {31'd0, misalign}, {31'd0, AlignEn});
    tick();
    check("misw_flag_hold", {31'd0, misalign}, {31'd0, AlignEn});
    finish_access();
    check("misw_flag_clr", {31'd0, misalign}, 32'd0);
    check("misw_valid_clr", {31'd0, addr_valid}, 32'd0);

    // Assorted sizes and alignments, checked through the scoreboard.
    tbl_sel[0] = 0; tbl_addr[0] = 32'h0000_0021; tbl_size[0] = 2'b01;
    tbl_sel[1] = 2; tbl_addr[1] = 32'h0000_0033; tbl_size[1] = 2'b00;
    tbl_sel[2] = 1; tbl_addr[2] = 32'h0000_0022; tbl_size[2] = 2'b01;
    tbl_sel[3] = 3; tbl_addr[3] = 32'h0000_0104; tbl_size[3] = 2'b11;
    tbl_sel[4] = 2; tbl_addr[4] = 32'h0000_0203; tbl_size[4] = 2'b11;
    for (int i = 0; i < 5; i++) begin
      start(tbl_sel[i], tbl_addr[i], tbl_size[i]);
      finish_access();
      check("tbl_idle", {31'd0, busy}, 32'd0);
    end

    // Out-of-range select falls back to the PC slot.
    src3[0] = 32'h0000_0020;
    src3[1] = 32'h0000_0055;
    src3[2] = 32'h0000_0066;
    sel3    = 2'd3;
    req3    = 1'b1;
    tick();
    req3 = 1'b0;
    check("oor_addr", addr_out3, 32'h20);
    check("oor_valid", {31'd0, addr_valid3}, 32'd1);
    mem_ready3 = 1'b1;
    tick();
    mem_ready3 = 1'b0;
    sel3 = 2'd2;
    req3 = 1'b1;
    tick();
    req3 = 1'b0;
    check("inrange_addr", addr_out3, 32'h66);
    mem_ready3 = 1'b1;
    tick();
    mem_ready3 = 1'b0;
    check("inrange_done", {31'd0, busy3}, 32'd0);

    // Watchdog expiry: four wait edges with no answer.
    start(2, 32'h0000_0400, 2'b10);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("wd_pending_timeout", {31'd0, timeout}, 32'd0);
      check("wd_pending_busy", {31'd0, busy}, 32'd1);
    end
    tick();
    check("wd_pulse", {31'd0, timeout}, 32'd1);
    check("wd_busy", {31'd0, busy}, 32'd0);
    check("wd_valid", {31'd0, addr_valid}, 32'd0);
    tick();
    check("wd_pulse_end", {31'd0, timeout}, 32'd0);

    // mem_ready on the expiry cycle: completion, no pulse.
    start(2, 32'h0000_0500, 2'b10);
    for (int i = 1; i <= 3; i++) tick();
    check("wdr_still_busy", {31'd0, busy}, 32'd1);
    finish_access();
    check("wdr_no_pulse", {31'd0, timeout}, 32'd0);
    check("wdr_valid", {31'd0, addr_valid}, 32'd0);
    tick();
    check("wdr_no_pulse_late", {31'd0, timeout}, 32'd0);

    // A request while busy is ignored.
    start(2, 32'h0000_0200, 2'b10);
    src[1] = 32'h0000_0300;
    sel    = 2'd1;
    req    = 1'b1;
    tick();
    req = 1'b0;
    check("busy_ignore_addr", addr_out, 32'h200);
    finish_access();
    check("busy_ignore_done", {31'd0, addr_valid}, 32'd0);
    tick();
    check("busy_ignore_idle", {31'd0, busy}, 32'd0);
    check("busy_ignore_keep", addr_out, 32'h200);

    // Asynchronous reset in the middle of an access.
    start(2, 32'h0000_0040, 2'b10);
    check("mid_addr", addr_out, 32'h40);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_addr", addr_out, 32'd0);
    check("mid_rst_valid", {31'd0, addr_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    check("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
